// File: rtl/poly_mul_pkg.sv
// Shared configuration for the schoolbook polynomial multiplier: default sizes,
// the accept-counter width rule and the sequencer FSM state type.
package poly_mul_pkg;

  // Default polynomial length in coefficients.
  localparam int PolyN = 256;
  // Default public / accumulator coefficient width.
  localparam int PolyCoefW = 13;
  // Default secret coefficient width (two's complement).
  localparam int PolySecW = 4;

  // Accept counter must hold the value N itself, hence one bit above log2.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Accept counter width for the default polynomial length.
  localparam int PolyCntW = cnt_width(PolyN);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/negacyclic_rotator.sv
// Negacyclic rotation of a packed secret polynomial by one position, i.e.
// multiplication by x modulo (x^N + 1). Purely combinational.
module negacyclic_rotator #(
  parameter int N     = 256,
  parameter int SEC_W = 4
) (
  input  logic [N*SEC_W-1:0] i_secret,
  output logic [N*SEC_W-1:0] o_secret
);

  logic [SEC_W-1:0] w_wrap_neg;

  // The coefficient falling off the top re-enters at index 0 negated.
  assign w_wrap_neg = -i_secret[(N-1)*SEC_W +: SEC_W];

  // Shift every coefficient up by one index; slot 0 takes the negated wrap.
  always_comb begin
    o_secret = '0;
    for (int j = 1; j < N; j++) begin
      o_secret[j*SEC_W +: SEC_W] = i_secret[(j-1)*SEC_W +: SEC_W];
    end
    o_secret[0 +: SEC_W] = w_wrap_neg;
  end

endmodule

// File: rtl/schoolbook_sequencer.sv
// Sequencer for a schoolbook negacyclic polynomial multiplier. It streams the
// public coefficients a[i] in, holds the rotated secret and the accumulator for
// an external combinational MAC array, and rotates the secret once per
// accumulate so that step i sees x^i * s mod (x^N + 1).
// Optional feature: define PRECOMP_MUL5_EN to drive a_mul_5 (secret -5..5);
// otherwise a_mul_5 is tied to 0 and secrets are limited to -4..4.
module schoolbook_sequencer
  import poly_mul_pkg::*;
#(
  parameter int N      = PolyN,
  parameter int COEF_W = PolyCoefW,
  parameter int SEC_W  = PolySecW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*SEC_W-1:0]  secret_in,
  input  logic                a_valid,
  input  logic [COEF_W-1:0]   a_data,
  output logic                a_ready,
  input  logic [N*COEF_W-1:0] mac_result,
  output logic [N*COEF_W-1:0] acc_out,
  output logic [N*SEC_W-1:0]  secret_out,
  output logic [COEF_W-1:0]   a_coeff,
  output logic [COEF_W-1:0]   a_mul_2,
  output logic [COEF_W-1:0]   a_mul_3,
  output logic [COEF_W-1:0]   a_mul_4,
  output logic [COEF_W-1:0]   a_mul_5,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] NCnt    = CNT_W'(N);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_stage_vld;
  logic [COEF_W-1:0]     r_a_coeff;
  logic [N*COEF_W-1:0]   r_acc;
  logic [N*SEC_W-1:0]    r_secret;

  logic                  w_a_ready;
  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_job_start;
  logic [N*SEC_W-1:0]    w_secret_rot;

  // Accept only in RUN and only until all N coefficients are in.
  assign w_a_ready   = (r_state == StRun) && (r_cnt < NCnt);
  assign w_hs        = a_valid && w_a_ready;
  assign w_last_hs   = w_hs && (r_cnt == LastCnt);
  assign w_job_start = (r_state == StIdle) && start;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (w_last_hs) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        // The N-th coefficient is accumulated in this cycle.
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = StDone;
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Accept counter: cleared on job start, saturates at N because a_ready drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_job_start) begin
      r_cnt <= '0;
    end else if (w_hs) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Coefficient stage: capture a[i] on handshake and flag it for accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_coeff   <= '0;
      r_stage_vld <= 1'b0;
    end else begin
      r_stage_vld <= w_hs;
      if (w_hs) begin
        r_a_coeff <= a_data;
      end
    end
  end

  // Accumulator and secret: load on start, update+rotate on each valid stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_secret <= '0;
    end else if (w_job_start) begin
      r_acc    <= '0;
      r_secret <= secret_in;
    end else if (r_stage_vld) begin
      r_acc    <= mac_result;
      r_secret <= w_secret_rot;
    end
  end

  negacyclic_rotator #(
    .N     (N),
    .SEC_W (SEC_W)
  ) u_rotator (
    .i_secret (r_secret),
    .o_secret (w_secret_rot)
  );

  // Small multiples of the staged coefficient for the MAC array, mod 2^COEF_W.
  always_comb begin
    a_mul_2 = {r_a_coeff[COEF_W-2:0], 1'b0};
    a_mul_4 = {r_a_coeff[COEF_W-3:0], 2'b00};
    a_mul_3 = a_mul_2 + r_a_coeff;
`ifdef PRECOMP_MUL5_EN
    a_mul_5 = a_mul_4 + r_a_coeff;
`else
    a_mul_5 = '0;
`endif
  end

  assign a_ready    = w_a_ready;
  assign a_coeff    = r_a_coeff;
  assign acc_out    = r_acc;
  assign secret_out = r_secret;

endmodule

// File: tb/tb_schoolbook_sequencer.sv
// Self-checking bench for schoolbook_sequencer with a behavioural MAC array
// and an independent negacyclic golden product.
module tb_schoolbook_sequencer;

  localparam int N  = 256;
  localparam int CW = 13;
  localparam int SW = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [N*SW-1:0]   secret_in;
  logic              a_valid;
  logic [CW-1:0]     a_data;
  logic              a_ready;
  logic [N*CW-1:0]   mac_result;
  logic [N*CW-1:0]   acc_out;
  logic [N*SW-1:0]   secret_out;
  logic [CW-1:0]     a_coeff;
  logic [CW-1:0]     a_mul_2;
  logic [CW-1:0]     a_mul_3;
  logic [CW-1:0]     a_mul_4;
  logic [CW-1:0]     a_mul_5;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  int a_arr [N];
  int s_arr [N];
  int gold  [N];

  typedef struct {
    logic [CW-1:0] a;
    logic [CW-1:0] m2;
    logic [CW-1:0] m3;
    logic [CW-1:0] m4;
    logic [CW-1:0] m5;
  } mul_vec_t;

  mul_vec_t vecs [6];

  schoolbook_sequencer #(
    .N      (N),
    .COEF_W (CW),
    .SEC_W  (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .secret_in  (secret_in),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .mac_result (mac_result),
    .acc_out    (acc_out),
    .secret_out (secret_out),
    .a_coeff    (a_coeff),
    .a_mul_2    (a_mul_2),
    .a_mul_3    (a_mul_3),
    .a_mul_4    (a_mul_4),
    .a_mul_5    (a_mul_5),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC array: acc + a_coeff * signed(secret), per coefficient.
  function automatic logic [CW-1:0] mac_coef(input logic [CW-1:0] acc, input logic [CW-1:0] a,
                                             input logic [SW-1:0] s);
    int t;
    t = int'(acc) + int'(a) * int'($signed(s));
    return t[CW-1:0];
  endfunction

  always_comb begin
    mac_result = '0;
    for (int j = 0; j < N; j++) begin
      mac_result[j*CW +: CW] = mac_coef(acc_out[j*CW +: CW], a_coeff, secret_out[j*SW +: SW]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_secret();
    for (int j = 0; j < N; j++) secret_in[j*SW +: SW] = SW'(s_arr[j]);
  endtask

  task automatic compute_gold();
    for (int k = 0; k < N; k++) gold[k] = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i + j < N) gold[i+j] += a_arr[i] * s_arr[j];
        else gold[i+j-N] -= a_arr[i] * s_arr[j];
      end
    end
    for (int k = 0; k < N; k++) gold[k] = gold[k] & ((1 << CW) - 1);
  endtask

  task automatic check_acc(input string name);
    int first;
    first = -1;
    for (int k = 0; k < N; k++) begin
      if (acc_out[k*CW +: CW] !== CW'(gold[k]) && first < 0) first = k;
    end
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: acc_out[%0d] got %0d expected %0d", name, first,
               acc_out[first*CW +: CW], gold[first]);
    end
  endtask

  // After N rotations the secret is x^N * s = -s.
  task automatic check_sec_neg(input string name);
    int first;
    logic [SW-1:0] e;
    first = -1;
    for (int k = 0; k < N; k++) begin
      e = SW'(-s_arr[k]);
      if (secret_out[k*SW +: SW] !== e && first < 0) first = k;
    end
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: secret_out[%0d] got %0d expected %0d", name, first,
               secret_out[first*SW +: SW], SW'(-s_arr[first]));
    end
  endtask

  // Runs one job from a_arr/s_arr. Cycle 1 is the start cycle; bub>0 drops
  // a_valid whenever cycle % bub == 0. Entered and left at posedge+1.
  task automatic run_job(input int bub, input bit keep_start, output int done_cyc,
                         output int pulses);
    int idx;
    int cyc;
    idx = 0;
    done_cyc = -1;
    pulses = 0;
    load_secret();
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 2;
    while (cyc < 2000 && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
      start   = keep_start && (done_cyc < 0 || cyc <= done_cyc + 1);
      a_valid = (idx < N) && !(bub > 0 && (cyc % bub) == 0);
      a_data  = (idx < N) ? CW'(a_arr[idx]) : '0;
      @(negedge clk);
      if (a_valid && a_ready) idx++;
      if (done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start   = 1'b0;
    a_valid = 1'b0;
  endtask

  task automatic job_checks(input string name, input int bub, input bit keep_start);
    int dc;
    int np;
    int hs;
    int c;
    int exp_done;
    hs = 0;
    c = 2;
    exp_done = 0;
    while (hs < N) begin
      if (!(bub > 0 && (c % bub) == 0)) begin
        hs++;
        exp_done = c + 1;
      end
      c++;
    end
    compute_gold();
    run_job(bub, keep_start, dc, np);
    chk({name, "_done_cycle"}, dc, exp_done);
    chk({name, "_done_pulses"}, np, 1);
    @(negedge clk);
    check_acc({name, "_acc"});
    check_sec_neg({name, "_secret_final"});
    chk({name, "_idle_busy"}, 32'(busy), 0);
    chk({name, "_idle_ready"}, 32'(a_ready), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int np;
    logic [CW-1:0] e5;

    vecs[0] = '{13'd1700, 13'd3400, 13'd5100, 13'd6800, 13'd308};
    vecs[1] = '{13'd0,    13'd0,    13'd0,    13'd0,    13'd0};
    vecs[2] = '{13'd8191, 13'd8190, 13'd8189, 13'd8188, 13'd8187};
    vecs[3] = '{13'd4096, 13'd0,    13'd4096, 13'd0,    13'd4096};
    vecs[4] = '{13'd1,    13'd2,    13'd3,    13'd4,    13'd5};
    vecs[5] = '{13'd5000, 13'd1808, 13'd6808, 13'd3616, 13'd424};

    rst = 1'b1; start = 1'b0; a_valid = 1'b0; a_data = '0; secret_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_acc", 32'(|acc_out), 0);
    chk("reset_secret", 32'(|secret_out), 0);
    chk("reset_coeff", 32'(a_coeff), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_ready", 32'(a_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // s = 1, a[i] = i: product is a itself.
    for (int i = 0; i < N; i++) begin a_arr[i] = i; s_arr[i] = 0; end
    s_arr[0] = 1;
    job_checks("identity", 0, 1'b0);
    chk("identity_acc255", 32'(acc_out[255*CW +: CW]), 255);

    // s = x^(N-1), a = x: product is x^N = -1.
    for (int i = 0; i < N; i++) begin a_arr[i] = 0; s_arr[i] = 0; end
    a_arr[1] = 1; s_arr[N-1] = 1;
    job_checks("wrap", 0, 1'b0);
    chk("wrap_acc0", 32'(acc_out[0 +: CW]), 8191);

    // Random operands, a_valid low every third cycle.
    for (int i = 0; i < N; i++) begin
      a_arr[i] = int'($urandom_range(0, 8191));
      s_arr[i] = int'($urandom_range(0, 10)) - 5;
    end
    job_checks("bubbles", 3, 1'b0);

    // Single accumulate with s[N-1] = -5, then bubble, then multiples table.
    for (int i = 0; i < N; i++) s_arr[i] = 0;
    s_arr[0] = 3; s_arr[N-1] = -5;
    load_secret();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; a_data = 13'd1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("one_coeff", 32'(a_coeff), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_sec0", 32'(secret_out[0 +: SW]), 5);
    chk("one_sec1", 32'(secret_out[SW +: SW]), 3);
    chk("one_acc0", 32'(acc_out[0 +: CW]), 3);
    chk("one_accN1", 32'(acc_out[(N-1)*CW +: CW]), 8187);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_sec0", 32'(secret_out[0 +: SW]), 5);
    chk("bubble_acc0", 32'(acc_out[0 +: CW]), 3);
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      a_valid = 1'b1; a_data = vecs[v].a;
      @(posedge clk); #1;
      a_valid = 1'b0;
      @(negedge clk);
`ifdef PRECOMP_MUL5_EN
      e5 = vecs[v].m5;
`else
      e5 = '0;
`endif
      chk($sformatf("vec%0d_coeff", v), 32'(a_coeff), 32'(vecs[v].a));
      chk($sformatf("vec%0d_mul2", v), 32'(a_mul_2), 32'(vecs[v].m2));
      chk($sformatf("vec%0d_mul3", v), 32'(a_mul_3), 32'(vecs[v].m3));
      chk($sformatf("vec%0d_mul4", v), 32'(a_mul_4), 32'(vecs[v].m4));
      chk($sformatf("vec%0d_mul5", v), 32'(a_mul_5), 32'(e5));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset at the 100th handshake abandons the job.
    for (int i = 0; i < N; i++) begin
      a_arr[i] = int'($urandom_range(0, 8191));
      s_arr[i] = int'($urandom_range(0, 10)) - 5;
    end
    load_secret();
    np = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1;
    for (int i = 0; i < 99; i++) begin
      a_data = CW'(a_arr[i]);
      @(negedge clk);
      if (done) np++;
      @(posedge clk); #1;
    end
    a_data = CW'(a_arr[99]);
    rst = 1'b1;
    @(negedge clk);
    if (done) np++;
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    chk("midrst_acc", 32'(|acc_out), 0);
    chk("midrst_secret", 32'(|secret_out), 0);
    chk("midrst_coeff", 32'(a_coeff), 0);
    chk("midrst_mul", 32'(a_mul_2 | a_mul_3 | a_mul_4 | a_mul_5), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(a_ready), 0);
    for (int i = 0; i < 5; i++) begin
      if (done) np++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("midrst_no_done", np, 0);
    @(posedge clk); #1;
    job_checks("after_rst", 0, 1'b0);

    // start held high through RUN/DRAIN/DONE must not restart the job.
    for (int i = 0; i < N; i++) begin
      a_arr[i] = int'($urandom_range(0, 8191));
      s_arr[i] = int'($urandom_range(0, 10)) - 5;
    end
    job_checks("held_start", 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
